// File: rtl/svc_axi_rd_arb2.sv
// Two-requester AXI read arbiter, one outstanding burst at a time.
// Define SVC_AXI_RD_ARB_RR_EN for round-robin; default is fixed priority (0 wins).
module svc_axi_rd_arb2 #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  s_axi_arvalid,
  input  logic [2*AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [2*AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [15:0]                 s_axi_arlen,
  output logic [1:0]                  s_axi_arready,
  output logic [1:0]                  s_axi_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  input  logic [1:0]                  s_axi_rready,
  output logic                        m_axi_arvalid,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  input  logic                        m_axi_arready,
  input  logic                        m_axi_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  output logic                        m_axi_rready
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state;
  logic   grant;
  logic   pick;
  logic   burst_done;

  assign burst_done = m_axi_rvalid & m_axi_rready & m_axi_rlast;

`ifdef SVC_AXI_RD_ARB_RR_EN
  logic ptr;

  // Pointer only matters when both requesters contend.
  always_comb begin
    pick = s_axi_arvalid[1];
    if (&s_axi_arvalid) pick = ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (state == DATA && burst_done) begin
      ptr <= ~grant;
    end
  end
`else
  always_comb pick = ~s_axi_arvalid[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|s_axi_arvalid) begin
            grant <= pick;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arvalid && m_axi_arready) state <= DATA;
        end
        DATA: begin
          if (burst_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_axi_arid   = s_axi_arid[AXI_ID_WIDTH-1:0];
    m_axi_araddr = s_axi_araddr[AXI_ADDR_WIDTH-1:0];
    m_axi_arlen  = s_axi_arlen[7:0];
    if (grant) begin
      m_axi_arid   = s_axi_arid[2*AXI_ID_WIDTH-1:AXI_ID_WIDTH];
      m_axi_araddr = s_axi_araddr[2*AXI_ADDR_WIDTH-1:AXI_ADDR_WIDTH];
      m_axi_arlen  = s_axi_arlen[15:8];
    end
  end

  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    s_axi_arready = 2'b00;
    s_axi_rvalid  = 2'b00;
    unique case (state)
      ADDR: begin
        m_axi_arvalid        = s_axi_arvalid[grant];
        s_axi_arready[grant] = m_axi_arready;
      end
      DATA: begin
        m_axi_rready        = s_axi_rready[grant];
        s_axi_rvalid[grant] = m_axi_rvalid;
      end
      default: ;
    endcase
  end

  assign s_axi_rdata = m_axi_rdata;
  assign s_axi_rresp = m_axi_rresp;
  assign s_axi_rlast = m_axi_rlast;

endmodule
